store_router: RTL
=================

STORE_ROUTER -- requirements
Module: store_router

Interface
REQ-001 SHALL have parameter DEPTH, default 2, d-cache write buffer entries; power of two, at least 2.
REQ-002 SHALL have parameter UOP_STR, default 5'd11, uOP code of STR.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port uop  input  5  current uOP.
REQ-006 SHALL have port addr  input  32  store address.
REQ-007 SHALL have port data  input  32  store data.
REQ-008 SHALL have port stall  output  1  store cannot be accepted this cycle.
REQ-009 SHALL have port dc_wr_valid  output  1  d-cache write request pending.
REQ-010 SHALL have port dc_wr_ready  input  1  d-cache takes the request this cycle.
REQ-011 SHALL have port dc_wr_addr  output  5  d-cache word address.
REQ-012 SHALL have port dc_wr_data  output  32  d-cache write data.
REQ-013 SHALL have port gpio_out  output  32  registered GPIO output state.
REQ-014 SHALL have port busy  output  1  buffer non-empty; pipeline holds LDR to d-cache while 1.
REQ-015 SHALL have port bad_addr  output  1  sticky: store to unmapped address seen.

Function
REQ-016 Store accepted iff uop==UOP_STR and stall==0 in that cycle; all other uOPs change no state.
REQ-017 Address map: addr<31 -> d-cache; addr==32 -> GPIO; addr==31 or addr>32 -> unmapped.
REQ-018 stall SHALL be combinational: 1 iff buffer count==DEPTH and uop==UOP_STR, regardless of target or same-cycle pop.
REQ-019 Accepted d-cache store SHALL push {addr[4:0], data} into FIFO; entry first visible on dc_wr_* the next cycle.
REQ-020 dc_wr_valid = buffer non-empty; dc_wr_addr/dc_wr_data = head entry, stable while valid and not ready.
REQ-021 Head popped at edge where dc_wr_valid && dc_wr_ready; entries leave in acceptance order.
REQ-022 Push and pop in same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-023 Accepted GPIO store SHALL load gpio_out with data at that edge, visible next cycle, independent of pending d-cache entries.
REQ-024 Accepted unmapped store SHALL be discarded and set bad_addr at that edge; bad_addr clears only on reset.
REQ-025 busy SHALL equal dc_wr_valid.

Reset
REQ-026 While rst=1 at an edge: buffer emptied, pointers and count zero, gpio_out=0, bad_addr=0.
REQ-027 Reset mid-operation SHALL discard buffered writes; dc_wr_valid=0 and busy=0 the cycle after.
REQ-028 Outputs after reset: stall=0 (unless full rule applies, impossible empty), dc_wr_addr=0, dc_wr_data=0.

Structure
REQ-029 Shared package cpu_pkg SHALL hold uOP codes (UOP_LDR=10, UOP_STR=11) and address map constants (DCACHE_LIMIT=31, GPIO_ADDR=32), also used by the load return mux.
REQ-030 FIFO SHALL be sub-module store_fifo (DEPTH, 37-bit entries, push/pop/full/empty/count).
REQ-031 Address decode SHALL be a single combinational classification reused for all routing.

Verification
REQ-032 STR addr=5 data=0xDEADBEEF, dc_wr_ready=1 -> next cycle dc_wr_valid=1, addr=5, data=0xDEADBEEF; popped; busy=0 after.
REQ-033 dc_wr_ready=0, STR to addr 1,2,3 back-to-back -> third STR sees stall=1; raise ready -> writes 1,2 then 3 in order.
REQ-034 STR addr=32 data=0x0000000F -> gpio_out=0xF next cycle; no dc_wr_valid.
REQ-035 STR addr=31, then addr=0x100 -> bad_addr=1 and stays; gpio_out and buffer unchanged.
REQ-036 Buffer full, ready=1 and STR same cycle -> stall=1, count drops to 1; STR accepted next cycle.
REQ-037 Two entries pending, rst pulsed 1 cycle -> dc_wr_valid=0, gpio_out=0, bad_addr=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: uOP codes and the data address map, used by the store
// router and the load return mux.
package cpu_pkg;

  localparam logic [4:0]  UOP_LDR      = 5'd10;
  localparam logic [4:0]  UOP_STR      = 5'd11;
  localparam logic [31:0] DCACHE_LIMIT = 32'd31;
  localparam logic [31:0] GPIO_ADDR    = 32'd32;

  localparam int unsigned ENTRY_W = 37;

  typedef enum logic [1:0] {
    DST_DCACHE,
    DST_GPIO,
    DST_UNMAPPED
  } dest_e;

  function automatic dest_e decode_addr(input logic [31:0] a);
    if (a < DCACHE_LIMIT)   return DST_DCACHE;
    else if (a == GPIO_ADDR) return DST_GPIO;
    else                     return DST_UNMAPPED;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular write buffer for d-cache stores; head entry is presented on pop_data.
module store_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_router.sv
// Routes accepted STR uOPs to the d-cache write buffer, the GPIO register, or
// flags them as unmapped.
module store_router #(
  parameter int unsigned DEPTH   = 2,
  parameter logic [4:0]  UOP_STR = 5'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  uop,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        stall,
  output logic        dc_wr_valid,
  input  logic        dc_wr_ready,
  output logic [4:0]  dc_wr_addr,
  output logic [31:0] dc_wr_data,
  output logic [31:0] gpio_out,
  output logic        busy,
  output logic        bad_addr
);

  import cpu_pkg::*;

  dest_e                dest;
  logic                 is_str;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [ENTRY_W-1:0]   head;
  logic [$clog2(DEPTH):0] count;

  assign dest   = decode_addr(addr);
  assign is_str = (uop == UOP_STR);
  // Stall depends only on fullness; a same-cycle pop does not free a slot early.
  assign stall  = is_str && full;
  assign accept = is_str && !stall;
  assign push   = accept && (dest == DST_DCACHE);
  assign pop    = dc_wr_valid && dc_wr_ready;

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({addr[4:0], data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign dc_wr_valid = !empty;
  assign busy        = dc_wr_valid;
  assign dc_wr_addr  = head[36:32];
  assign dc_wr_data  = head[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= '0;
      bad_addr <= 1'b0;
    end else if (accept) begin
      if (dest == DST_GPIO)     gpio_out <= data;
      if (dest == DST_UNMAPPED) bad_addr <= 1'b1;
    end
  end

endmodule
